// File: rtl/qmux_sel_ctrl.sv
// qmux_sel_ctrl
//
// Sequences a change of the IS select on a QMUX global-clock multiplexer.
// A request is taken over a valid/ready handshake. For a real change the
// downstream clock enable is dropped first, IS is switched while the gate is
// closed, IS is held for a settle window, and then the enable is restored
// and completion is reported. A request for the value IS already has
// completes at once with a DONE pulse and touches nothing else.
//
// Runs on an always-on control clock that is independent of both muxed
// clocks. IS and CEN come straight from flops, so neither can glitch.
//
// Ports
//   QCK        in   control clock, rising-edge active
//   QRT        in   synchronous active-high reset
//   SEL_REQ    in   requested select (0 = GMUXIN, 1 = QHSCK), sampled on accept
//   REQ_VALID  in   request valid
//   REQ_READY  out  high in IDLE only (decoded from the state register)
//   IS         out  registered select to the QMUX
//   CEN        out  registered clock enable, low while switching
//   BUSY       out  high outside IDLE (decoded from the state register)
//   DONE       out  one-cycle registered completion pulse
//   SWCNT      out  number of completed real switches, wraps at 256
//
// State    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | waiting for a request; CEN high, IS stable
// GATE     | CEN low, waiting GATE_CYCLES for the gate to close cleanly
// SWITCH   | single cycle in which IS takes the target value
// SETTLE   | CEN still low, IS held for SETTLE_CYCLES before re-enabling

module qmux_sel_ctrl #(
    parameter int GATE_CYCLES   = 4,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic       QCK,
    input  logic       QRT,
    input  logic       SEL_REQ,
    input  logic       REQ_VALID,
    output logic       REQ_READY,
    output logic       IS,
    output logic       CEN,
    output logic       BUSY,
    output logic       DONE,
    output logic [7:0] SWCNT
);

    if (GATE_CYCLES < 1 || GATE_CYCLES > 255) begin : g_bad_gate
        $error("qmux_sel_ctrl: GATE_CYCLES must be in 1..255");
    end
    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_bad_settle
        $error("qmux_sel_ctrl: SETTLE_CYCLES must be in 1..255");
    end

    // Down-counter reload values; the terminal count is zero, so a window of
    // N cycles loads N-1.
    localparam logic [7:0] GATE_LOAD   = 8'(GATE_CYCLES - 1);
    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GATE   = 2'd1,
        ST_SWITCH = 2'd2,
        ST_SETTLE = 2'd3
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] cnt;
    logic [7:0] cnt_nxt;
    logic       tgt;
    logic       tgt_nxt;
    logic       is_nxt;
    logic       cen_nxt;
    logic       done_nxt;
    logic [7:0] swcnt_nxt;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        tgt_nxt   = tgt;
        is_nxt    = IS;
        cen_nxt   = CEN;
        done_nxt  = 1'b0;
        swcnt_nxt = SWCNT;

        case (state)
            ST_IDLE: begin
                if (REQ_VALID) begin
                    if (SEL_REQ == IS) begin
                        done_nxt = 1'b1;
                    end else begin
                        tgt_nxt   = SEL_REQ;
                        cen_nxt   = 1'b0;
                        cnt_nxt   = GATE_LOAD;
                        state_nxt = ST_GATE;
                    end
                end
            end
            ST_GATE: begin
                if (cnt == 8'd0) begin
                    state_nxt = ST_SWITCH;
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            ST_SWITCH: begin
                is_nxt    = tgt;
                cnt_nxt   = SETTLE_LOAD;
                state_nxt = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (cnt == 8'd0) begin
                    cen_nxt   = 1'b1;
                    done_nxt  = 1'b1;
                    swcnt_nxt = SWCNT + 8'd1;
                    state_nxt = ST_IDLE;
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge QCK) begin
        if (QRT) begin
            state <= ST_IDLE;
            cnt   <= 8'd0;
            tgt   <= 1'b0;
            IS    <= 1'b0;
            CEN   <= 1'b1;
            DONE  <= 1'b0;
            SWCNT <= 8'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            tgt   <= tgt_nxt;
            IS    <= is_nxt;
            CEN   <= cen_nxt;
            DONE  <= done_nxt;
            SWCNT <= swcnt_nxt;
        end
    end

    assign REQ_READY = (state == ST_IDLE);
    assign BUSY      = (state != ST_IDLE);

endmodule

// File: tb/tb_qmux_sel_ctrl.sv
// Directed bench for qmux_sel_ctrl. One instance runs with the default
// 4/4 windows, a second with 1/1 windows for the short-timing and wrap case.
// Status vectors are packed as {IS, CEN, DONE, REQ_READY, BUSY}.

module tb_qmux_sel_ctrl;

    logic       clk;
    logic       rst, sel, valid;
    logic       ready, is_o, cen, busy, done;
    logic [7:0] swcnt;
    logic       rst_f, sel_f, valid_f;
    logic       ready_f, is_f, cen_f, busy_f, done_f;
    logic [7:0] swcnt_f;
    logic [4:0] st, st_f;

    int n_vec = 0;
    int n_err = 0;

    qmux_sel_ctrl #(.GATE_CYCLES(4), .SETTLE_CYCLES(4)) dut (
        .QCK(clk), .QRT(rst), .SEL_REQ(sel), .REQ_VALID(valid),
        .REQ_READY(ready), .IS(is_o), .CEN(cen), .BUSY(busy),
        .DONE(done), .SWCNT(swcnt)
    );

    qmux_sel_ctrl #(.GATE_CYCLES(1), .SETTLE_CYCLES(1)) dut_f (
        .QCK(clk), .QRT(rst_f), .SEL_REQ(sel_f), .REQ_VALID(valid_f),
        .REQ_READY(ready_f), .IS(is_f), .CEN(cen_f), .BUSY(busy_f),
        .DONE(done_f), .SWCNT(swcnt_f)
    );

    assign st   = {is_o, cen, done, ready, busy};
    assign st_f = {is_f, cen_f, done_f, ready_f, busy_f};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge; outputs are then read 1 ns after that edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [4:0] exp;
        rst = 1'b1; rst_f = 1'b1;
        valid = 1'b0; valid_f = 1'b0; sel = 1'b0; sel_f = 1'b0;
        tick();
        tick();
        rst = 1'b0; rst_f = 1'b0;
        exp = 5'b01010;
        for (int k = 0; k < 10; k++) begin
            n_vec++;
            if (st !== exp || swcnt !== 8'd0) begin
                n_err++;
                $display("FAIL reset_idle k=%0d: got st=%b swcnt=%0d, expected st=%b swcnt=0",
                         k, st, swcnt, exp);
            end
            tick();
        end
        n_vec++;
        if (st_f !== exp || swcnt_f !== 8'd0) begin
            n_err++;
            $display("FAIL reset_fast: got st=%b swcnt=%0d, expected st=%b swcnt=0",
                     st_f, swcnt_f, exp);
        end
    endtask

    task automatic test_single_switch();
        logic [4:0] exp;
        logic [7:0] exp_cnt;
        sel = 1'b1; valid = 1'b1;
        tick();                                  // accept edge t
        valid = 1'b0; sel = 1'b0;
        for (int k = 0; k <= 10; k++) begin
            exp     = {k >= 5, k >= 9, k == 9, k >= 9, k < 9};
            exp_cnt = (k >= 9) ? 8'd1 : 8'd0;
            n_vec++;
            if (st !== exp || swcnt !== exp_cnt) begin
                n_err++;
                $display("FAIL single_switch t+%0d: got st=%b swcnt=%0d, expected st=%b swcnt=%0d",
                         k, st, swcnt, exp, exp_cnt);
            end
            if (k < 10) tick();
        end
    endtask

    task automatic test_noop();
        sel = 1'b1; valid = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            n_vec++;
            if (st !== 5'b11110 || swcnt !== 8'd1) begin
                n_err++;
                $display("FAIL noop_accept %0d: got st=%b swcnt=%0d, expected st=11110 swcnt=1",
                         k, st, swcnt);
            end
        end
        valid = 1'b0;
        tick();
        n_vec++;
        if (st !== 5'b11010 || swcnt !== 8'd1) begin
            n_err++;
            $display("FAIL noop_after: got st=%b swcnt=%0d, expected st=11010 swcnt=1",
                     st, swcnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] exp;
        logic [7:0] exp_cnt;
        logic       prev;
        int         edges;
        sel = 1'b0; valid = 1'b1;
        tick();                                  // accept edge t, target 0
        prev  = 1'b1;
        edges = 0;
        for (int k = 0; k <= 9; k++) begin
            if (is_o !== prev) edges++;
            prev    = is_o;
            exp     = (k < 9) ? {k < 5, 4'b0001} : 5'b01110;
            exp_cnt = (k < 9) ? 8'd1 : 8'd2;
            n_vec++;
            if (st !== exp || swcnt !== exp_cnt) begin
                n_err++;
                $display("FAIL busy_hold t+%0d: got st=%b swcnt=%0d, expected st=%b swcnt=%0d",
                         k, st, swcnt, exp, exp_cnt);
            end
            // Toggling SEL_REQ while busy must be ignored; the last value
            // asks for a real switch so the next accept shows on CEN.
            sel = (k == 9) ? 1'b1 : ~sel;
            tick();
        end
        n_vec++;
        if (edges !== 1) begin
            n_err++;
            $display("FAIL busy_is_edges: got %0d IS edges, expected 1", edges);
        end
        n_vec++;
        if (st !== 5'b00001) begin
            n_err++;
            $display("FAIL second_accept t+10: got st=%b, expected st=00001", st);
        end
        valid = 1'b0;
        repeat (9) tick();
        n_vec++;
        if (st !== 5'b11110 || swcnt !== 8'd3) begin
            n_err++;
            $display("FAIL second_done: got st=%b swcnt=%0d, expected st=11110 swcnt=3",
                     st, swcnt);
        end
    endtask

    task automatic test_reset_mid();
        sel = 1'b0; valid = 1'b1;
        tick();
        valid = 1'b0;
        repeat (9) tick();
        n_vec++;
        if (st !== 5'b01110 || swcnt !== 8'd4) begin
            n_err++;
            $display("FAIL pre_reset_switch: got st=%b swcnt=%0d, expected st=01110 swcnt=4",
                     st, swcnt);
        end
        sel = 1'b1; valid = 1'b1;
        tick();
        valid = 1'b0;
        repeat (6) tick();
        n_vec++;
        if (st !== 5'b10001) begin
            n_err++;
            $display("FAIL in_settle: got st=%b, expected st=10001", st);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_vec++;
        if (st !== 5'b01010 || swcnt !== 8'd0) begin
            n_err++;
            $display("FAIL reset_mid: got st=%b swcnt=%0d, expected st=01010 swcnt=0",
                     st, swcnt);
        end
        for (int k = 0; k < 5; k++) begin
            tick();
            n_vec++;
            if (st !== 5'b01010) begin
                n_err++;
                $display("FAIL post_reset k=%0d: got st=%b, expected st=01010", k, st);
            end
        end
    endtask

    task automatic test_wrap();
        logic [12:0] exp;
        for (int i = 0; i < 256; i++) begin
            sel_f = (i % 2 == 0);
            valid_f = 1'b1;
            tick();                              // accept edge t
            valid_f = 1'b0;
            if (i == 0) begin
                n_vec++;
                if (st_f !== 5'b00001) begin
                    n_err++;
                    $display("FAIL fast_t0: got st=%b, expected st=00001", st_f);
                end
            end
            tick();
            if (i == 0) begin
                n_vec++;
                if (st_f !== 5'b00001) begin
                    n_err++;
                    $display("FAIL fast_t1: got st=%b, expected st=00001", st_f);
                end
            end
            tick();
            if (i == 0) begin
                n_vec++;
                if (st_f !== 5'b10001) begin
                    n_err++;
                    $display("FAIL fast_t2: got st=%b, expected st=10001", st_f);
                end
            end
            tick();
            exp = {sel_f, 4'b1110, 8'(i + 1)};
            n_vec++;
            if ({st_f, swcnt_f} !== exp) begin
                n_err++;
                $display("FAIL fast_done i=%0d: got st=%b swcnt=%0d, expected st=%b swcnt=%0d",
                         i, st_f, swcnt_f, exp[12:8], exp[7:0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_switch();
        test_noop();
        test_back_to_back();
        test_reset_mid();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
